// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and the instruction memory.
// The master drives the request and address; the slave answers with ready and the instruction word.
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, addr, input  ready, rdata);
  modport slave  (input  req, addr, output ready, rdata);
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, instruction-memory handshake, decode register and redirect handling.
// Optional macro FETCH_ALIGN_CHECK_EN adds misalign_o and word-aligns redirect targets.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               pc_src_d_i,
  input  logic        [31:0] pc_branch_d_i,
  input  logic         [2:0] jump_d_i,
  input  logic        [31:0] reg_data_1_d_i,
  fetch_stage_if.master      imem,
  output logic        [31:0] instr_d_o,
  output logic        [31:0] pc_plus_4_d_o,
  output logic               valid_d_o
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic               misalign_o
`endif
);

  localparam logic [0:0] S_REQ  = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic  [0:0] r_state;
  logic        r_started;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic        r_pend_vld;
  logic [31:0] r_pend_pc;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc4;

  logic        w_redirect;
  logic [31:0] w_target_raw;
  logic [31:0] w_target;
  logic [31:0] w_pc_inc;
  logic        w_unused_link;

  // Link bit only matters to the register-write side of decode.
  assign w_unused_link = jump_d_i[2];

  assign w_pc_inc   = r_pc + 32'd4;
  assign w_redirect = (pc_src_d_i | jump_d_i[0] | jump_d_i[1]) & r_valid & ~stall_i;

  always_comb begin
    w_target_raw = pc_branch_d_i;
    if (jump_d_i[1])
      w_target_raw = reg_data_1_d_i;
    else if (jump_d_i[0])
      w_target_raw = {r_pc4[31:28], r_instr[25:0], 2'b00};
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_misalign;
  assign w_target   = {w_target_raw[31:2], 2'b00};
  assign misalign_o = r_misalign;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      r_misalign <= 1'b0;
    else
      r_misalign <= w_redirect & (|w_target_raw[1:0]);
  end
`else
  assign w_target = w_target_raw;
`endif

  assign imem.req      = r_started & (r_state == S_REQ);
  assign imem.addr     = r_pc;
  assign instr_d_o     = r_instr;
  assign pc_plus_4_d_o = r_pc4;
  assign valid_d_o     = r_valid;

  // r_started keeps the request low for the first edge after reset release.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_REQ;
      r_started   <= 1'b0;
      r_pc        <= RESET_PC;
      r_instr     <= 32'd0;
      r_pc4       <= 32'd0;
      r_valid     <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_pc   <= 32'd0;
      r_buf_instr <= 32'd0;
      r_buf_pc4   <= 32'd0;
    end else if (!r_started) begin
      r_started <= 1'b1;
    end else begin
      case (r_state)
        S_REQ: begin
          if (imem.ready) begin
            if (r_pend_vld) begin
              r_pc       <= r_pend_pc;
              r_pend_vld <= 1'b0;
              if (!stall_i) begin
                r_instr <= 32'd0;
                r_valid <= 1'b0;
              end
            end else if (w_redirect) begin
              r_pc    <= w_target;
              r_instr <= 32'd0;
              r_valid <= 1'b0;
            end else if (stall_i) begin
              r_buf_instr <= imem.rdata;
              r_buf_pc4   <= w_pc_inc;
              r_state     <= S_HOLD;
            end else begin
              r_instr <= imem.rdata;
              r_pc4   <= w_pc_inc;
              r_valid <= 1'b1;
              r_pc    <= w_pc_inc;
            end
          end else if (!stall_i) begin
            // Address must stay put until ready, so a redirect waits in the pending register.
            r_instr <= 32'd0;
            r_valid <= 1'b0;
            if (w_redirect) begin
              r_pend_vld <= 1'b1;
              r_pend_pc  <= w_target;
            end
          end
        end
        default: begin
          if (!stall_i) begin
            if (w_redirect) begin
              r_pc    <= w_target;
              r_instr <= 32'd0;
              r_valid <= 1'b0;
            end else begin
              r_instr <= r_buf_instr;
              r_pc4   <= r_buf_pc4;
              r_valid <= 1'b1;
              r_pc    <= r_buf_pc4;
            end
            r_state <= S_REQ;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table of per-cycle inputs and expected outputs,
// followed by back-to-back, asynchronous-reset and optional alignment sequences.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        psrc = 1'b0;
  logic [31:0] br = 32'd0;
  logic  [2:0] jmp = 3'd0;
  logic [31:0] rd1 = 32'd0;
  logic        rdy = 1'b0;
  logic [31:0] instr_d;
  logic [31:0] pc4_d;
  logic        valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .stall_i        (stall),
    .pc_src_d_i     (psrc),
    .pc_branch_d_i  (br),
    .jump_d_i       (jmp),
    .reg_data_1_d_i (rd1),
    .imem           (bus),
    .instr_d_o      (instr_d),
    .pc_plus_4_d_o  (pc4_d),
    .valid_d_o      (valid_d)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .misalign_o     (misalign)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: each word encodes its address, except a J instruction (index 0x40) at 0x1000_0000.
  assign bus.ready = rdy;
  always_comb begin
    if (bus.addr == 32'h1000_0000)
      bus.rdata = 32'h0800_0040;
    else
      bus.rdata = 32'hE000_0000 | bus.addr;
  end

  typedef struct {
    logic        rdy;
    logic        stall;
    logic        psrc;
    logic [31:0] br;
    logic  [2:0] jmp;
    logic [31:0] rd1;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic s, input logic p, input logic [31:0] b,
                     input logic [2:0] j, input logic [31:0] d, input logic er,
                     input logic [31:0] ea, input logic ev, input logic [31:0] ei,
                     input logic [31:0] ep);
    vec_t v;
    v.rdy = r; v.stall = s; v.psrc = p; v.br = b; v.jmp = j; v.rd1 = d;
    v.e_req = er; v.e_addr = ea; v.e_vld = ev; v.e_instr = ei; v.e_pc4 = ep;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    stall = 1'b0; psrc = 1'b0; br = 32'd0; jmp = 3'd0; rd1 = 32'd0;
  endtask

  initial begin
    //  rdy stall psrc br            jmp   rd1        | req addr           vld instr          pc4
    add(1, 0, 0, 32'h0,         3'd0, 32'h0,   0, 32'h0,         0, 32'h0,         32'h0);
    add(1, 0, 0, 32'h0,         3'd0, 32'h0,   1, 32'h0,         0, 32'h0,         32'h0);
    add(1, 0, 0, 32'h0,         3'd0, 32'h0,   1, 32'h4,         1, 32'hE000_0000, 32'h4);
    add(0, 0, 0, 32'h0,         3'd0, 32'h0,   1, 32'h8,         1, 32'hE000_0004, 32'h8);
    add(0, 0, 0, 32'h0,         3'd0, 32'h0,   1, 32'h8,         0, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,         3'd0, 32'h0,   1, 32'h8,         0, 32'h0,         32'h0);
    add(1, 0, 0, 32'h0,         3'd0, 32'h0,   1, 32'h8,         0, 32'h0,         32'h0);
    add(1, 0, 0, 32'h0,         3'd0, 32'h0,   1, 32'hC,         1, 32'hE000_0008, 32'hC);
    add(1, 1, 0, 32'h0,         3'd0, 32'h0,   1, 32'h10,        1, 32'hE000_000C, 32'h10);
    add(1, 1, 0, 32'h0,         3'd0, 32'h0,   0, 32'h10,        1, 32'hE000_000C, 32'h10);
    add(0, 0, 0, 32'h0,         3'd0, 32'h0,   0, 32'h10,        1, 32'hE000_000C, 32'h10);
    add(1, 0, 0, 32'h0,         3'd0, 32'h0,   1, 32'h14,        1, 32'hE000_0010, 32'h14);
    add(1, 0, 0, 32'h0,         3'd0, 32'h0,   1, 32'h18,        1, 32'hE000_0014, 32'h18);
    add(1, 0, 0, 32'h0,         3'd0, 32'h0,   1, 32'h1C,        1, 32'hE000_0018, 32'h1C);
    add(0, 0, 1, 32'h100,       3'd0, 32'h0,   1, 32'h20,        1, 32'hE000_001C, 32'h20);
    add(0, 0, 1, 32'h300,       3'd0, 32'h0,   1, 32'h20,        0, 32'h0,         32'h0);
    add(1, 0, 0, 32'h0,         3'd0, 32'h0,   1, 32'h20,        0, 32'h0,         32'h0);
    add(1, 0, 0, 32'h0,         3'd0, 32'h0,   1, 32'h100,       0, 32'h0,         32'h0);
    add(1, 0, 1, 32'h300,       3'd2, 32'h200, 1, 32'h104,       1, 32'hE000_0100, 32'h104);
    add(1, 0, 0, 32'h0,         3'd0, 32'h0,   1, 32'h200,       0, 32'h0,         32'h0);
    add(1, 0, 1, 32'h1000_0000, 3'd0, 32'h0,   1, 32'h204,       1, 32'hE000_0200, 32'h204);
    add(1, 0, 0, 32'h0,         3'd0, 32'h0,   1, 32'h1000_0000, 0, 32'h0,         32'h0);
    add(1, 0, 0, 32'h0,         3'd1, 32'h0,   1, 32'h1000_0004, 1, 32'h0800_0040, 32'h1000_0004);
    add(1, 0, 0, 32'h0,         3'd0, 32'h0,   1, 32'h1000_0100, 0, 32'h0,         32'h0);
    add(1, 1, 0, 32'h0,         3'd0, 32'h0,   1, 32'h1000_0104, 1, 32'hF000_0100, 32'h1000_0104);
    add(1, 0, 1, 32'h40,        3'd0, 32'h0,   0, 32'h1000_0104, 1, 32'hF000_0100, 32'h1000_0104);
    add(1, 0, 0, 32'h0,         3'd0, 32'h0,   1, 32'h40,        0, 32'h0,         32'h0);
    add(0, 1, 0, 32'h0,         3'd0, 32'h0,   1, 32'h44,        1, 32'hE000_0040, 32'h44);
    add(0, 0, 0, 32'h0,         3'd0, 32'h0,   1, 32'h44,        1, 32'hE000_0040, 32'h44);
    add(1, 0, 0, 32'h0,         3'd0, 32'h0,   1, 32'h44,        0, 32'h0,         32'h0);
    add(1, 0, 1, 32'hFFFF_FFFC, 3'd0, 32'h0,   1, 32'h48,        1, 32'hE000_0044, 32'h48);
    add(1, 0, 0, 32'h0,         3'd0, 32'h0,   1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,         3'd0, 32'h0,   1, 32'h0,         1, 32'hFFFF_FFFC, 32'h0);

    // Reset state
    #1;
    chk("rst_req",   {31'd0, bus.req}, 32'd0);
    chk("rst_addr",  bus.addr, 32'd0);
    chk("rst_valid", {31'd0, valid_d}, 32'd0);
    chk("rst_instr", instr_d, 32'd0);
    chk("rst_pc4",   pc4_d, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      chk($sformatf("v%0d_req", i),   {31'd0, bus.req}, {31'd0, vq[i].e_req});
      chk($sformatf("v%0d_addr", i),  bus.addr, vq[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'd0, valid_d}, {31'd0, vq[i].e_vld});
      chk($sformatf("v%0d_instr", i), instr_d, vq[i].e_instr);
      if (vq[i].e_vld)
        chk($sformatf("v%0d_pc4", i), pc4_d, vq[i].e_pc4);
      rdy = vq[i].rdy; stall = vq[i].stall; psrc = vq[i].psrc;
      br = vq[i].br; jmp = vq[i].jmp; rd1 = vq[i].rd1;
      @(negedge clk);
    end

    // Back-to-back ready from address 0 after the wrap
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b%0d_addr", i), bus.addr, 32'(4 * i));
      chk($sformatf("b2b%0d_valid", i), {31'd0, valid_d}, (i > 0) ? 32'd1 : 32'd0);
      if (i > 0)
        chk($sformatf("b2b%0d_pc4", i), pc4_d, 32'(4 * i));
      rdy = 1'b1;
      @(negedge clk);
    end

    // Reset asserted mid-transaction takes effect without a clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req",   {31'd0, bus.req}, 32'd0);
    chk("mid_rst_addr",  bus.addr, 32'd0);
    chk("mid_rst_valid", {31'd0, valid_d}, 32'd0);
    chk("mid_rst_instr", instr_d, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_req_low", {31'd0, bus.req}, 32'd0);
    @(negedge clk);
    chk("rel_req_high", {31'd0, bus.req}, 32'd1);
    chk("rel_addr", bus.addr, 32'd0);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned JR target
    rdy = 1'b1;
    @(negedge clk);
    chk("al_valid", {31'd0, valid_d}, 32'd1);
    chk("al_mis_idle", {31'd0, misalign}, 32'd0);
    jmp = 3'd2; rd1 = 32'h203;
    @(negedge clk);
    drive_idle();
    chk("al_mis_pulse", {31'd0, misalign}, 32'd1);
    chk("al_addr", bus.addr, 32'h200);
    @(negedge clk);
    chk("al_mis_clear", {31'd0, misalign}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
